// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    // Operand width used when the instantiating level does not override it.
    localparam int DEFAULT_WIDTH = 4;

    // Control states: waiting for work, shifting bits, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_add.sv
// One-bit full-adder cell, gate-level like the rest of the half/full cell family.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    // Sum is the parity of the three inputs; carry is their majority.
    xor g_x1 (ab_x, a, b);
    xor g_x2 (s, ab_x, cin);
    and g_a1 (ab_a, a, b);
    and g_a2 (cx_a, ab_x, cin);
    or  g_o1 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop compute a + b + cin
// LSB-first over WIDTH clocks, behind a start/ready/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Wide enough to hold WIDTH itself, so the count never wraps early.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic               carry_q;
    logic [WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ready_q;
    logic               done_q;

    logic               bit_d;
    logic               carry_d;
    logic [WIDTH-1:0]   res_d;

    // The single shared cell works on the current LSBs and the stored carry.
    full_add u_fa (
        .a    (op_a_q[0]),
        .b    (op_b_q[0]),
        .cin  (carry_q),
        .s    (bit_d),
        .cout (carry_d)
    );

    // Result fills from the MSB end so bit 0 lands in place after WIDTH shifts.
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

    // Control FSM, operand/result shifting and registered outputs.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand/result shift registers are reset too, so an
            // aborted operation leaves no stale data visible after reset.
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= b;
                        carry_q <= cin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    op_a_q  <= op_a_q >> 1;
                    op_b_q  <= op_b_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=4 and WIDTH=8.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       ready4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       ready8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .ready (ready4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .ready (ready8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 operation with latency and handshake checks.
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic [3:0] es, input logic ec);
        a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
        tick();                              // E0: accepted
        start4 = 1'b0;
        a4 = ~a; b4 = ~b; cin4 = ~cin;       // captured copies must be used
        check({tag, "_ready_low"}, 32'(ready4), 32'd0);
        repeat (3) tick();                   // E1..E3
        check({tag, "_no_early_done"}, 32'(done4), 32'd0);
        tick();                              // E4
        check({tag, "_done"}, 32'(done4), 32'd1);
        check({tag, "_ready_in_done"}, 32'(ready4), 32'd0);
        check({tag, "_sum"}, 32'(sum4), 32'(es));
        check({tag, "_cout"}, 32'(cout4), 32'(ec));
        tick();                              // back in IDLE
        check({tag, "_done_pulse_end"}, 32'(done4), 32'd0);
        check({tag, "_ready_back"}, 32'(ready4), 32'd1);
        check({tag, "_sum_held"}, 32'(sum4), 32'(es));
    endtask

    initial begin
        int pulses;
        int first_at;
        int second_at;
        int stable_ok;
        int extra_done;

        rst = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_ready", 32'(ready4), 32'd1);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_sum", 32'(sum4), 32'd0);
        check("rst_cout", 32'(cout4), 32'd0);
        check("rst_ready8", 32'(ready8), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic additions and the carry/overflow boundaries.
        run4("t1", 4'b1011, 4'b1111, 1'b0, 4'b1010, 1'b1);
        run4("t2a", 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0);
        run4("t2b", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
        run4("tmax", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);

        // Start during RUN/DONE must be ignored.
        a4 = 4'b0011; b4 = 4'b0101; cin4 = 1'b0; start4 = 1'b1;
        tick();                              // E0
        a4 = 4'b1111; b4 = 4'b1111;          // start stays high while busy
        repeat (4) tick();                   // E1..E4
        check("ign_done", 32'(done4), 32'd1);
        check("ign_sum", 32'(sum4), 32'h8);
        check("ign_cout", 32'(cout4), 32'd0);
        start4 = 1'b0;
        extra_done = 0;
        repeat (8) begin
            tick();
            if (done4) extra_done++;
        end
        check("ign_no_extra_done", 32'(extra_done), 32'd0);
        check("ign_sum_held", 32'(sum4), 32'h8);

        // Asynchronous reset mid-operation aborts it.
        a4 = 4'b0110; b4 = 4'b0001; cin4 = 1'b0; start4 = 1'b1;
        tick();                              // E0
        start4 = 1'b0;
        repeat (2) tick();                   // E1, E2
        rst = 1'b1;
        #1;
        check("abort_sum", 32'(sum4), 32'd0);
        check("abort_cout", 32'(cout4), 32'd0);
        check("abort_ready", 32'(ready4), 32'd1);
        check("abort_done", 32'(done4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        repeat (8) begin
            tick();
            if (done4) extra_done++;
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        run4("t4", 4'b0110, 4'b0001, 1'b0, 4'b0111, 1'b0);

        // Start held continuously: one op per WIDTH+2 cycles.
        a4 = 4'b0111; b4 = 4'b0110; cin4 = 1'b1; start4 = 1'b1;
        pulses = 0; first_at = 0; second_at = 0; stable_ok = 1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (done4) begin
                pulses++;
                if (pulses == 1) first_at = i;
                else if (pulses == 2) second_at = i;
                if (sum4 !== 4'hE) stable_ok = 0;
            end else if (pulses >= 1 && sum4 !== 4'hE) begin
                stable_ok = 0;
            end
        end
        start4 = 1'b0;
        check("hold_pulses", 32'(pulses), 32'd2);
        check("hold_first_at", 32'(first_at), 32'd5);
        check("hold_spacing", 32'(second_at - first_at), 32'd6);
        check("hold_sum_stable", 32'(stable_ok), 32'd1);
        repeat (8) tick();
        check("hold_drained_ready", 32'(ready4), 32'd1);

        // WIDTH=8 regression.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();                              // E0
        start8 = 1'b0;
        check("w8_ready_low", 32'(ready8), 32'd0);
        repeat (7) tick();
        check("w8_no_early_done", 32'(done8), 32'd0);
        tick();                              // E8
        check("w8_done", 32'(done8), 32'd1);
        check("w8_sum", 32'(sum8), 32'h00);
        check("w8_cout", 32'(cout8), 32'd1);
        tick();
        check("w8_done_end", 32'(done8), 32'd0);
        check("w8_ready_back", 32'(ready8), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
